// File: rtl/shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter with valid/ready handshakes on both sides.
// Define SHIFT_UNIT_FAST_EN to swap the one-bit-per-cycle datapath for a single-cycle barrel shift.
module shift_unit #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic             r_carry;
  logic [WIDTH-1:0] w_shData;
  logic             w_shCarry;

`ifdef SHIFT_UNIT_FAST_EN
  // WIDTH - amt wraps to 0 for amt 0, which makes the ROR left term a no-op.
  logic [AMT_W-1:0] w_lslIdx;
  logic [AMT_W-1:0] w_rIdx;

  assign w_lslIdx = AMT_W'(WIDTH - int'(r_cnt));
  assign w_rIdx   = r_cnt - 1'b1;

  always_comb begin
    w_shData  = r_data;
    w_shCarry = 1'b0;
    case (r_mode)
      2'b00: begin
        w_shData  = r_data << r_cnt;
        w_shCarry = (r_cnt != '0) && r_data[w_lslIdx];
      end
      2'b01: begin
        w_shData  = r_data >> r_cnt;
        w_shCarry = (r_cnt != '0) && r_data[w_rIdx];
      end
      2'b10: begin
        w_shData  = $signed(r_data) >>> r_cnt;
        w_shCarry = (r_cnt != '0) && r_data[w_rIdx];
      end
      default: begin
        w_shData  = (r_data >> r_cnt) | (r_data << w_lslIdx);
        w_shCarry = (r_cnt != '0) && r_data[w_rIdx];
      end
    endcase
  end
`else
  always_comb begin
    w_shData  = r_data;
    w_shCarry = 1'b0;
    case (r_mode)
      2'b00: begin
        w_shData  = {r_data[WIDTH-2:0], 1'b0};
        w_shCarry = r_data[WIDTH-1];
      end
      2'b01: begin
        w_shData  = {1'b0, r_data[WIDTH-1:1]};
        w_shCarry = r_data[0];
      end
      2'b10: begin
        w_shData  = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
        w_shCarry = r_data[0];
      end
      default: begin
        w_shData  = {r_data[0], r_data[WIDTH-1:1]};
        w_shCarry = r_data[0];
      end
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
`ifdef SHIFT_UNIT_FAST_EN
        w_nextState = DONE;
`else
        if (r_cnt == '0) begin
          w_nextState = DONE;
        end
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The working register doubles as the result register, so DONE holds it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_cnt   <= in_amt;
            r_mode  <= in_mode;
            r_carry <= 1'b0;
          end
        end
        SHIFT: begin
`ifdef SHIFT_UNIT_FAST_EN
          r_data  <= w_shData;
          r_carry <= w_shCarry;
`else
          if (r_cnt != '0) begin
            r_data  <= w_shData;
            r_carry <= w_shCarry;
            r_cnt   <= r_cnt - 1'b1;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data  = r_data;
  assign out_carry = r_carry;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: driver pushes model results, a negedge monitor pops on handshake.
module tb_shift_unit;
  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [AMT_W-1:0] in_amt = '0;
  logic [1:0]       in_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;

  int nTests = 0;
  int nFail = 0;
  int edgeCnt = 0;
  int readyMode = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             carry;
    int               amt;
    int               acceptEdge;
  } exp_t;

  exp_t sbq[$];

  logic             prevValid = 1'b0;
  logic [WIDTH-1:0] prevData = '0;
  logic             prevCarry = 1'b0;

  shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Shift rules written with wide integer arithmetic rather than bit stepping.
  function automatic void refModel(input logic [WIDTH-1:0] d, input int amt, input int mode,
                                   output logic [WIDTH-1:0] r, output logic c);
    longint unsigned u;
    longint          s;
    u = longint'(d);
    s = longint'($signed(d));
    c = 1'b0;
    case (mode)
      0: begin
        r = WIDTH'(u << amt);
        if (amt != 0) c = ((u >> (WIDTH - amt)) & 1) != 0;
      end
      1: begin
        r = WIDTH'(u >> amt);
        if (amt != 0) c = ((u >> (amt - 1)) & 1) != 0;
      end
      2: begin
        r = WIDTH'(s >>> amt);
        if (amt != 0) c = ((u >> (amt - 1)) & 1) != 0;
      end
      default: begin
        r = WIDTH'((u >> amt) | (u << (WIDTH - amt)));
        if (amt != 0) c = ((u >> (amt - 1)) & 1) != 0;
      end
    endcase
  endfunction

  function automatic int expLat(input int amt);
`ifdef SHIFT_UNIT_FAST_EN
    return 1;
`else
    return amt + 1;
`endif
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input int amt, input int mode);
    int waitCnt;
    exp_t e;
    waitCnt = 0;
    @(negedge clk);
    while (!in_ready && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = AMT_W'(amt);
    in_mode  = 2'(mode);
    refModel(d, amt, mode, e.data, e.carry);
    e.amt        = amt;
    e.acceptEdge = edgeCnt + 1;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    in_amt   = AMT_W'($urandom);
    in_mode  = 2'($urandom);
  endtask

  task automatic drain();
    int waitCnt;
    waitCnt = 0;
    while (sbq.size() != 0 && waitCnt < 500) begin
      @(negedge clk);
      waitCnt++;
    end
    if (sbq.size() != 0) checkOutput("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: latency on the rising out_valid, stability while held, result on handshake.
  always @(negedge clk) begin
    logic newReady;
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (out_valid) checkOutput("ready_valid_exclusive", 64'(in_ready), 64'd0);
      if (out_valid && !prevValid) begin
        if (sbq.size() == 0) checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
        else checkOutput("latency", 64'(edgeCnt - sbq[0].acceptEdge), 64'(expLat(sbq[0].amt)));
      end
      if (out_valid && prevValid) begin
        checkOutput("hold_data", 64'(out_data), 64'(prevData));
        checkOutput("hold_carry", 64'(out_carry), 64'(prevCarry));
      end
      case (readyMode)
        0: newReady = 1'($urandom_range(0, 1));
        1: newReady = 1'b0;
        default: newReady = 1'b1;
      endcase
      out_ready = newReady;
      if (out_valid && newReady && sbq.size() != 0) begin
        checkOutput("result_data", 64'(out_data), 64'(sbq[0].data));
        checkOutput("result_carry", 64'(out_carry), 64'(sbq[0].carry));
        void'(sbq.pop_front());
      end
      prevValid = out_valid;
      prevData  = out_data;
      prevCarry = out_carry;
    end
  end

  initial begin
    int waitCnt;
    int seenValid;

    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_out_carry", 64'(out_carry), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    readyMode = 2;
    applyStimulus(16'h0001, 4, 0);
    applyStimulus(16'h8004, 2, 2);
    applyStimulus(16'hFFFF, 15, 1);
    applyStimulus(16'h0003, 1, 3);
    for (int m = 0; m < 4; m++) applyStimulus(16'h1234, 0, m);
    drain();

    // Hold out_ready low and offer a competing request that must be refused.
    readyMode = 1;
    applyStimulus(16'hA5C3, 3, 1);
    waitCnt = 0;
    while (!out_valid && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("hold_reached_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h5555;
      in_amt   = 4'd7;
      in_mode  = 2'b00;
      @(negedge clk);
      #1;
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    readyMode = 2;
    drain();

    readyMode = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(WIDTH'($urandom), int'($urandom_range(0, WIDTH - 1)), int'($urandom_range(0, 3)));
    end
    readyMode = 2;
    drain();

    // Reset in the middle of a request: outputs clear at once and nothing appears afterwards.
    readyMode = 1;
    applyStimulus(16'h00FF, 8, 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out_data", 64'(out_data), 64'd0);
    checkOutput("midreset_out_carry", 64'(out_carry), 64'd0);
    readyMode = 2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("postreset_in_ready", 64'(in_ready), 64'd1);
    seenValid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seenValid++;
    end
    checkOutput("postreset_no_stale", 64'(seenValid), 64'd0);

    applyStimulus(16'hC001, 5, 2);
    drain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
